wb_byte_loader: RTL and testbench

- Byte-stream to Wishbone master bridge that sits directly upstream of the 4-bit CPU system's Wishbone backdoor.
- Parses host command packets arriving as bytes from a UART or SPI front end.
- Issues single Wishbone reads or writes that load and inspect ROM and RAM images.
- Returns a status byte or read data on an outbound byte stream.

---
 rtl/wb_byte_loader.sv | 197 +++++++++++++++++++
 tb/tb_wb_byte_loader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_byte_loader.sv
// Byte-stream to Wishbone master bridge: parses 'W'/'R' command packets and answers
// with 'K', 'E' or four read-data bytes. Define LOADER_AUTOINC_EN for 'w'/'r' auto-increment.
module wb_byte_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_strobe_o,
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StWb,
        StResp
    } state_e;

    localparam logic [7:0]  CmdWrite = 8'h57;
    localparam logic [7:0]  CmdRead  = 8'h52;
    localparam logic [7:0]  RspOk    = 8'h4B;
    localparam logic [7:0]  RspErr   = 8'h45;
    localparam logic [15:0] TmoLast  = 16'(TIMEOUT_CYCLES - 1);

    state_e      r_state, w_state;
    logic [1:0]  r_cnt, w_cnt;
    logic [31:0] r_addr, w_addr;
    logic [31:0] r_data, w_data;
    logic [31:0] r_rdata, w_rdata;
    logic        r_we, w_we;
    logic        r_err, w_err;
    logic [15:0] r_tmo, w_tmo;
    logic        w_rx_fire;
    logic        w_tx_fire;
    logic        w_last_tx;

    assign rx_ready    = (r_state == StIdle) || (r_state == StAddr) || (r_state == StData);
    assign tx_valid    = (r_state == StResp);
    assign wb_cyc_o    = (r_state == StWb);
    assign wb_strobe_o = (r_state == StWb);
    assign busy        = (r_state != StIdle);
    assign wb_addr_o   = r_addr;
    assign wb_data_o   = r_data;
    assign wb_we_o     = r_we;

    assign w_rx_fire = rx_valid && rx_ready;
    assign w_tx_fire = tx_valid && tx_ready;
    // Errors and write acks are single-byte responses; reads send four bytes.
    assign w_last_tx = r_err || r_we || (r_cnt == 2'd3);

    always_comb begin
        tx_data = 8'h00;
        if (r_err) begin
            tx_data = RspErr;
        end else if (r_we) begin
            tx_data = RspOk;
        end else begin
            unique case (r_cnt)
                2'd0:    tx_data = r_rdata[31:24];
                2'd1:    tx_data = r_rdata[23:16];
                2'd2:    tx_data = r_rdata[15:8];
                default: tx_data = r_rdata[7:0];
            endcase
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_addr  = r_addr;
        w_data  = r_data;
        w_rdata = r_rdata;
        w_we    = r_we;
        w_err   = r_err;
        w_tmo   = r_tmo;
        unique case (r_state)
            StIdle: begin
                if (w_rx_fire) begin
                    case (rx_data)
                        CmdWrite: begin
                            w_we    = 1'b1;
                            w_cnt   = 2'd0;
                            w_state = StAddr;
                        end
                        CmdRead: begin
                            w_we    = 1'b0;
                            w_cnt   = 2'd0;
                            w_state = StAddr;
                        end
`ifdef LOADER_AUTOINC_EN
                        8'h77: begin
                            w_we    = 1'b1;
                            w_cnt   = 2'd0;
                            w_state = StData;
                        end
                        8'h72: begin
                            w_we    = 1'b0;
                            w_tmo   = 16'd0;
                            w_state = StWb;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            StAddr: begin
                if (w_rx_fire) begin
                    w_addr = {r_addr[23:0], rx_data};
                    w_cnt  = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_cnt   = 2'd0;
                        w_tmo   = 16'd0;
                        w_state = r_we ? StData : StWb;
                    end
                end
            end
            StData: begin
                if (w_rx_fire) begin
                    w_data = {r_data[23:0], rx_data};
                    w_cnt  = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_cnt   = 2'd0;
                        w_tmo   = 16'd0;
                        w_state = StWb;
                    end
                end
            end
            StWb: begin
                // Ack beats the timeout when both land on the same cycle.
                if (wb_ack_i) begin
                    if (!r_we) begin
                        w_rdata = wb_data_i;
                    end
`ifdef LOADER_AUTOINC_EN
                    w_addr = r_addr + 32'd4;
`endif
                    w_err   = 1'b0;
                    w_cnt   = 2'd0;
                    w_state = StResp;
                end else if (r_tmo == TmoLast) begin
                    w_err   = 1'b1;
                    w_cnt   = 2'd0;
                    w_state = StResp;
                end else begin
                    w_tmo = r_tmo + 16'd1;
                end
            end
            StResp: begin
                if (w_tx_fire) begin
                    if (w_last_tx) begin
                        w_cnt   = 2'd0;
                        w_state = StIdle;
                    end else begin
                        w_cnt = r_cnt + 2'd1;
                    end
                end
            end
            default: w_state = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_cnt   <= 2'd0;
            r_addr  <= 32'd0;
            r_data  <= 32'd0;
            r_rdata <= 32'd0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_tmo   <= 16'd0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_rdata <= w_rdata;
            r_we    <= w_we;
            r_err   <= w_err;
            r_tmo   <= w_tmo;
        end
    end

endmodule

// File: tb/tb_wb_byte_loader.sv
// Self-checking bench for wb_byte_loader: directed scenarios plus randomized packets
// checked against a transaction-level model of the command protocol.
module tb_wb_byte_loader;

    localparam int unsigned TMO = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_strobe_o;
    logic [31:0] wb_data_i = 32'h0;
    logic        wb_ack_i = 1'b0;
    logic        busy;

    wb_byte_loader #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .wb_addr_o   (wb_addr_o),
        .wb_data_o   (wb_data_o),
        .wb_we_o     (wb_we_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_strobe_o (wb_strobe_o),
        .wb_data_i   (wb_data_i),
        .wb_ack_i    (wb_ack_i),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Wishbone slave state; ack_delay == 0 means never acknowledge.
    int          ack_delay = 0;
    int          s_cnt = 0;
    int          last_len = 0;
    bit          stable_err = 1'b0;
    logic [31:0] s_addr0, s_data0;
    logic        s_we0;
    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic        log_we [$];
    logic [7:0]  resp_q [$];

    // Reference model state.
    logic [31:0] model_addr = 32'h0;
    logic [31:0] model_mem [logic [31:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (wb_cyc_o && wb_strobe_o) begin
                if (s_cnt == 0) begin
                    s_addr0 = wb_addr_o;
                    s_data0 = wb_data_o;
                    s_we0   = wb_we_o;
                end else if (wb_addr_o !== s_addr0 || wb_data_o !== s_data0 ||
                             wb_we_o !== s_we0) begin
                    stable_err = 1'b1;
                end
                s_cnt = s_cnt + 1;
                if (ack_delay != 0 && s_cnt == ack_delay) begin
                    wb_ack_i = 1'b1;
                    log_addr.push_back(wb_addr_o);
                    log_we.push_back(wb_we_o);
                    if (wb_we_o) begin
                        slave_mem[wb_addr_o] = wb_data_o;
                        log_data.push_back(wb_data_o);
                        wb_data_i = $urandom;
                    end else begin
                        wb_data_i = slave_mem.exists(wb_addr_o) ? slave_mem[wb_addr_o]
                                                                : ~wb_addr_o;
                        log_data.push_back(wb_data_i);
                    end
                end else begin
                    wb_ack_i  = 1'b0;
                    wb_data_i = $urandom;
                end
            end else begin
                if (s_cnt != 0) last_len = s_cnt;
                s_cnt    = 0;
                wb_ack_i = 1'b0;
            end
        end
    end

    // Called and returns on a falling edge.
    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && w < 50) begin
            @(negedge clock);
            w++;
        end
        if (rx_ready !== 1'b1) check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
        @(negedge clock);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_pkt(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                            input bit with_addr, input bit with_data);
        logic [31:0] v;
        send_byte(cmd);
        if (with_addr) begin
            v = a;
            for (int i = 0; i < 4; i++) begin
                send_byte(v[31:24]);
                v = v << 8;
            end
        end
        if (with_data) begin
            v = d;
            for (int i = 0; i < 4; i++) begin
                send_byte(v[31:24]);
                v = v << 8;
            end
        end
    endtask

    task automatic recv(input int n, input int stall);
        int w;
        logic [7:0] first;
        for (int k = 0; k < n; k++) begin
            w = 0;
            while (tx_valid !== 1'b1 && w < 100) begin
                @(negedge clock);
                w++;
            end
            if (tx_valid !== 1'b1) begin
                check("tx_valid_wait", {31'd0, tx_valid}, 32'd1);
                return;
            end
            first = tx_data;
            for (int s = 0; s < stall; s++) begin
                @(negedge clock);
                check("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, first});
            end
            tx_ready = 1'b1;
            resp_q.push_back(tx_data);
            @(negedge clock);
            tx_ready = 1'b0;
        end
    endtask

    // One command through the bridge, checked against the protocol model.
    task automatic txn(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                       input int ackd, input int stall, input string tag);
        bit          we, has_a, has_d, ok;
        logic [31:0] ta, rd;
        logic [7:0]  exp_q [$];
        int          n0;
        has_a = (cmd == 8'h57) || (cmd == 8'h52);
        has_d = (cmd == 8'h57) || (cmd == 8'h77);
        we    = has_d;
        ta    = has_a ? a : model_addr;
        ok    = (ackd >= 1) && (ackd <= int'(TMO));
        rd    = model_mem.exists(ta) ? model_mem[ta] : ~ta;
        if (!ok) exp_q.push_back(8'h45);
        else if (we) exp_q.push_back(8'h4B);
        else begin
            exp_q.push_back(rd[31:24]);
            exp_q.push_back(rd[23:16]);
            exp_q.push_back(rd[15:8]);
            exp_q.push_back(rd[7:0]);
        end
        n0 = log_addr.size();
        resp_q.delete();
        stable_err = 1'b0;
        ack_delay  = ackd;
        send_pkt(cmd, a, d, has_a, has_d);
        recv(exp_q.size(), stall);
        check({tag, "_resp_len"}, 32'(resp_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < resp_q.size(); i++)
            check({tag, "_resp_byte"}, {24'd0, resp_q[i]}, {24'd0, exp_q[i]});
        check({tag, "_wb_count"}, 32'(log_addr.size() - n0), {31'd0, ok});
        if (ok && log_addr.size() > n0) begin
            check({tag, "_wb_addr"}, log_addr[n0], ta);
            check({tag, "_wb_we"}, {31'd0, log_we[n0]}, {31'd0, we});
            check({tag, "_wb_data"}, log_data[n0], we ? d : rd);
        end
        if (!ok) check({tag, "_cyc_len"}, 32'(last_len), TMO);
        check({tag, "_wb_stable"}, {31'd0, stable_err}, 32'd0);
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        check({tag, "_tx_after"}, {31'd0, tx_valid}, 32'd0);
        if (ok && we) model_mem[ta] = d;
        model_addr = ta;
`ifdef LOADER_AUTOINC_EN
        if (ok) model_addr = ta + 32'd4;
`endif
    endtask

    initial begin
        int n0;
        logic [7:0]  cmd, junk;
        logic [31:0] a;
        bit done;

        #1;
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cyc", {30'd0, wb_cyc_o, wb_strobe_o}, 32'd0);
        check("rst_we", {31'd0, wb_we_o}, 32'd0);
        check("rst_addr", wb_addr_o, 32'd0);
        check("rst_data", wb_data_o, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        txn(8'h57, 32'h0000_0010, 32'hDEAD_BEEF, 2, 0, "write");

        slave_mem[32'h0001_0200] = 32'h1234_5678;
        model_mem[32'h0001_0200] = 32'h1234_5678;
        txn(8'h52, 32'h0001_0200, 32'h0, 1, 3, "read_stall");

        txn(8'h52, 32'h0000_0040, 32'h0, 0, 0, "timeout");
        n0 = log_addr.size();
        send_byte(8'hAA);
        repeat (3) @(negedge clock);
        check("junk_busy", {31'd0, busy}, 32'd0);
        check("junk_tx", {31'd0, tx_valid}, 32'd0);
        check("junk_wb", 32'(log_addr.size() - n0), 32'd0);
        txn(8'h57, 32'h0000_0044, 32'hCAFE_F00D, 1, 1, "after_timeout");

        txn(8'h57, 32'h0000_0080, 32'h0BAD_CAFE, 4, 0, "collision");

        // Reset in the middle of a bus cycle must drop cyc/strobe without a clock edge.
        ack_delay = 0;
        send_pkt(8'h52, 32'h0000_0100, 32'h0, 1'b1, 1'b0);
        done = 1'b0;
        for (int w = 0; w < 20 && !done; w++) begin
            if (wb_cyc_o === 1'b1) done = 1'b1;
            else @(negedge clock);
        end
        check("rst_wb_reached", {31'd0, wb_cyc_o}, 32'd1);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("rst_wb_cyc", {30'd0, wb_cyc_o, wb_strobe_o}, 32'd0);
        check("rst_wb_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_wb_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_wb_busy", {31'd0, busy}, 32'd0);
        check("rst_wb_addr", wb_addr_o, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        model_addr = 32'h0;
        @(negedge clock);

        txn(8'h57, 32'hFFFF_FFFC, 32'h5555_AAAA, 2, 0, "wrap_write");
`ifdef LOADER_AUTOINC_EN
        txn(8'h77, 32'h0, 32'h1122_3344, 2, 0, "autoinc_write");
`else
        n0 = log_addr.size();
        send_pkt(8'h77, 32'h0, 32'h1122_3344, 1'b0, 1'b1);
        repeat (8) @(negedge clock);
        check("no_autoinc_wb", 32'(log_addr.size() - n0), 32'd0);
        check("no_autoinc_tx", {31'd0, tx_valid}, 32'd0);
        check("no_autoinc_busy", {31'd0, busy}, 32'd0);
        check("no_autoinc_addr", wb_addr_o, 32'hFFFF_FFFC);
`endif

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                junk = 8'($urandom);
                if (junk == 8'h57 || junk == 8'h52 || junk == 8'h77 || junk == 8'h72)
                    junk = 8'h00;
                send_byte(junk);
            end
`ifdef LOADER_AUTOINC_EN
            case ($urandom_range(0, 3))
                0:       cmd = 8'h57;
                1:       cmd = 8'h52;
                2:       cmd = 8'h77;
                default: cmd = 8'h72;
            endcase
`else
            cmd = ($urandom_range(0, 1) == 0) ? 8'h57 : 8'h52;
`endif
            a = ($urandom_range(0, 1) == 0) ? {27'd0, 3'($urandom_range(0, 7)), 2'b00}
                                            : $urandom;
            txn(cmd, a, $urandom, $urandom_range(0, 5), $urandom_range(0, 2), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
